// File: rtl/pc_state_sequencer.sv
// pc_state_sequencer
//   Consumer end of the 33-bit decoder control word. Owns the architectural
//   program counter, the 2-bit control-unit state register and the 5-bit
//   status register. It executes only the PC-related fields, controlword[6:0]:
//     pc_en[6], pc_fs[5:4], pc_in_sel[3], status_load[2], next_state[1:0]
//   Bits [32:7] belong to the other datapath consumers and are ignored here.
//
// Ports
//   clock               rising-edge system clock
//   reset               asynchronous, active-low reset
//   controlword[32:0]   decoder control word
//   constant[63:0]      sign-extended immediate from the decoder
//   data_bus_in[63:0]   data bus value (register or ALU result)
//   status_in[4:0]      ALU flags {V,C,N,Z,Z64}
//   stall               freezes all state for this cycle
//   instr_addr[63:0]    current PC, used as the fetch address
//   data_bus_out[63:0]  link value PC+PC_STEP while pc_en is set, else 0
//   data_bus_pc_enable  PC is driving the data bus
//   state[1:0]          current control-unit state
//   status[4:0]         registered status flags
//   align_fault         sticky flag: a branch produced a misaligned target
//
// Optional build macro PC_BRANCH_HISTORY_EN adds a 4-entry branch-source
// history:
//   hist_index[1:0]     0 selects the most recent entry
//   hist_pc[63:0]       selected branch-source PC
//   hist_count[2:0]     number of valid entries, saturating at 4
module pc_state_sequencer #(
  parameter logic [63:0] PC_RESET = 64'h0,
  parameter logic [63:0] PC_STEP  = 64'd4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [32:0] controlword,
  input  logic [63:0] constant,
  input  logic [63:0] data_bus_in,
  input  logic [4:0]  status_in,
  input  logic        stall,
`ifdef PC_BRANCH_HISTORY_EN
  input  logic [1:0]  hist_index,
  output logic [63:0] hist_pc,
  output logic [2:0]  hist_count,
`endif
  output logic [63:0] instr_addr,
  output logic [63:0] data_bus_out,
  output logic        data_bus_pc_enable,
  output logic [1:0]  state,
  output logic [4:0]  status,
  output logic        align_fault
);

  typedef enum logic [1:0] {
    CU_S0 = 2'b00,
    CU_S1 = 2'b01,
    CU_S2 = 2'b10,
    CU_S3 = 2'b11
  } cu_state_t;

  typedef enum logic [1:0] {
    PC_HOLD = 2'b00,
    PC_INC  = 2'b01,
    PC_ABS  = 2'b10,
    PC_REL  = 2'b11
  } pc_fs_t;

  logic        pc_en;
  pc_fs_t      pc_fs;
  logic        pc_in_sel;
  logic        status_load;
  cu_state_t   next_state;

  logic [63:0] pc_q;
  cu_state_t   state_q;
  logic [4:0]  status_q;
  logic        align_fault_q;

  logic [63:0] operand;
  logic [63:0] pc_plus_step;
  logic [63:0] next_pc;
  logic        is_branch;

  // Fields owned by the other consumers of the control word.
  logic        unused_cw_bits;
  assign unused_cw_bits = ^controlword[32:7];

  assign pc_en       = controlword[6];
  assign pc_fs       = pc_fs_t'(controlword[5:4]);
  assign pc_in_sel   = controlword[3];
  assign status_load = controlword[2];
  assign next_state  = cu_state_t'(controlword[1:0]);

  assign operand      = pc_in_sel ? constant : data_bus_in;
  assign pc_plus_step = pc_q + PC_STEP;
  assign is_branch    = (pc_fs == PC_ABS) || (pc_fs == PC_REL);

  always_comb begin
    next_pc = pc_q;
    unique case (pc_fs)
      PC_HOLD: next_pc = pc_q;
      PC_INC:  next_pc = pc_plus_step;
      PC_ABS:  next_pc = operand;
      PC_REL:  next_pc = pc_q + {operand[61:0], 2'b00};
      default: next_pc = pc_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q          <= PC_RESET;
      state_q       <= CU_S0;
      status_q      <= '0;
      align_fault_q <= 1'b0;
    end else if (!stall) begin
      pc_q    <= next_pc;
      state_q <= next_state;
      if (status_load) begin
        status_q <= status_in;
      end
      if (is_branch && (next_pc[1:0] != 2'b00)) begin
        align_fault_q <= 1'b1;
      end
    end
  end

  // The bus drive is combinational from the control word, so it is gated
  // with reset to keep the bus quiet while the block is held in reset.
  assign data_bus_pc_enable = pc_en & reset;
  assign data_bus_out       = data_bus_pc_enable ? pc_plus_step : '0;

  assign instr_addr  = pc_q;
  assign state       = state_q;
  assign status      = status_q;
  assign align_fault = align_fault_q;

`ifdef PC_BRANCH_HISTORY_EN
  logic [63:0] hist_mem [4];
  logic [1:0]  hist_wr_ptr;
  logic [2:0]  hist_cnt_q;
  logic [1:0]  hist_rd_ptr;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hist_wr_ptr <= '0;
      hist_cnt_q  <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        hist_mem[i] <= '0;
      end
    end else if (!stall && is_branch) begin
      hist_mem[hist_wr_ptr] <= pc_q;
      hist_wr_ptr           <= hist_wr_ptr + 2'd1;
      if (hist_cnt_q != 3'd4) begin
        hist_cnt_q <= hist_cnt_q + 3'd1;
      end
    end
  end

  // 2-bit arithmetic gives the mod-4 wrap; index 0 is the newest entry.
  assign hist_rd_ptr = hist_wr_ptr - 2'd1 - hist_index;
  assign hist_pc     = hist_mem[hist_rd_ptr];
  assign hist_count  = hist_cnt_q;
`endif

endmodule

// File: tb/tb_pc_state_sequencer.sv
module tb_pc_state_sequencer;

  logic        clock;
  logic        reset;
  logic [32:0] controlword;
  logic [63:0] constant;
  logic [63:0] data_bus_in;
  logic [4:0]  status_in;
  logic        stall;
  logic [63:0] instr_addr;
  logic [63:0] data_bus_out;
  logic        data_bus_pc_enable;
  logic [1:0]  state;
  logic [4:0]  status;
  logic        align_fault;
`ifdef PC_BRANCH_HISTORY_EN
  logic [1:0]  hist_index;
  logic [63:0] hist_pc;
  logic [2:0]  hist_count;
`endif

  int checks = 0;
  int errors = 0;

  pc_state_sequencer #(
    .PC_RESET(64'h0),
    .PC_STEP (64'd4)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .controlword       (controlword),
    .constant          (constant),
    .data_bus_in       (data_bus_in),
    .status_in         (status_in),
    .stall             (stall),
`ifdef PC_BRANCH_HISTORY_EN
    .hist_index        (hist_index),
    .hist_pc           (hist_pc),
    .hist_count        (hist_count),
`endif
    .instr_addr        (instr_addr),
    .data_bus_out      (data_bus_out),
    .data_bus_pc_enable(data_bus_pc_enable),
    .state             (state),
    .status            (status),
    .align_fault       (align_fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Upper bits carry a junk pattern: this block must ignore them.
  task automatic set_cw(input logic pc_en, input logic [1:0] pc_fs,
                        input logic pc_in_sel, input logic status_load,
                        input logic [1:0] next_state);
    controlword = {26'h2AAAAAA, pc_en, pc_fs, pc_in_sel, status_load, next_state};
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    #1;
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    stall = 1'b0;
    constant = '0;
    data_bus_in = '0;
    status_in = 5'h15;
    set_cw(1'b1, 2'b01, 1'b0, 1'b1, 2'b01);
    tick();
    tick();
    checks++; if (instr_addr !== 64'h0) begin errors++; $display("FAIL reset_pc: got %h expected %h", instr_addr, 64'h0); end
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL reset_state: got %h expected %h", state, 2'b00); end
    checks++; if (status !== 5'h00) begin errors++; $display("FAIL reset_status: got %h expected %h", status, 5'h00); end
    checks++; if (align_fault !== 1'b0) begin errors++; $display("FAIL reset_align: got %b expected 0", align_fault); end
    checks++; if (data_bus_pc_enable !== 1'b0) begin errors++; $display("FAIL reset_dbe: got %b expected 0", data_bus_pc_enable); end
    checks++; if (data_bus_out !== 64'h0) begin errors++; $display("FAIL reset_dbo: got %h expected %h", data_bus_out, 64'h0); end
    @(negedge clock);
    reset = 1'b1;
    set_cw(1'b0, 2'b01, 1'b0, 1'b0, 2'b01);
    tick();
    checks++; if (instr_addr !== 64'd4) begin errors++; $display("FAIL inc_pc1: got %h expected %h", instr_addr, 64'd4); end
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL inc_state1: got %h expected %h", state, 2'd1); end
    set_cw(1'b0, 2'b01, 1'b0, 1'b0, 2'b10);
    tick();
    checks++; if (instr_addr !== 64'd8) begin errors++; $display("FAIL inc_pc2: got %h expected %h", instr_addr, 64'd8); end
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL inc_state2: got %h expected %h", state, 2'd2); end
    set_cw(1'b0, 2'b01, 1'b0, 1'b0, 2'b11);
    tick();
    checks++; if (instr_addr !== 64'd12) begin errors++; $display("FAIL inc_pc3: got %h expected %h", instr_addr, 64'd12); end
    checks++; if (state !== 2'd3) begin errors++; $display("FAIL inc_state3: got %h expected %h", state, 2'd3); end
    // Status was never loaded, status_load stayed 0.
    checks++; if (status !== 5'h00) begin errors++; $display("FAIL status_noload: got %h expected %h", status, 5'h00); end
  endtask

  task automatic test_relative_branch();
    set_cw(1'b0, 2'b00, 1'b0, 1'b0, 2'b00);
    tick();
    checks++; if (instr_addr !== 64'd12) begin errors++; $display("FAIL hold_pc: got %h expected %h", instr_addr, 64'd12); end
    constant = 64'h100;
    set_cw(1'b0, 2'b10, 1'b1, 1'b0, 2'b00);
    tick();
    checks++; if (instr_addr !== 64'h100) begin errors++; $display("FAIL abs_const_pc: got %h expected %h", instr_addr, 64'h100); end
    set_cw(1'b1, 2'b00, 1'b0, 1'b0, 2'b00);
    #1;
    checks++; if (data_bus_out !== 64'h104) begin errors++; $display("FAIL link_value: got %h expected %h", data_bus_out, 64'h104); end
    checks++; if (data_bus_pc_enable !== 1'b1) begin errors++; $display("FAIL link_enable: got %b expected 1", data_bus_pc_enable); end
    constant = 64'hFFFF_FFFF_FFFF_FFFC;
    data_bus_in = 64'h7;
    set_cw(1'b0, 2'b11, 1'b1, 1'b0, 2'b00);
    tick();
    checks++; if (instr_addr !== 64'hF0) begin errors++; $display("FAIL rel_branch_pc: got %h expected %h", instr_addr, 64'hF0); end
    checks++; if (align_fault !== 1'b0) begin errors++; $display("FAIL rel_branch_align: got %b expected 0", align_fault); end
    // Relative branch via the data bus: 0xF0 + (3<<2) = 0xFC.
    data_bus_in = 64'h3;
    set_cw(1'b0, 2'b11, 1'b0, 1'b0, 2'b00);
    tick();
    checks++; if (instr_addr !== 64'hFC) begin errors++; $display("FAIL rel_bus_pc: got %h expected %h", instr_addr, 64'hFC); end
  endtask

  task automatic test_abs_fault();
    data_bus_in = 64'h2002;
    constant = 64'h0;
    set_cw(1'b0, 2'b10, 1'b0, 1'b0, 2'b00);
    tick();
    checks++; if (instr_addr !== 64'h2002) begin errors++; $display("FAIL abs_fault_pc: got %h expected %h", instr_addr, 64'h2002); end
    checks++; if (align_fault !== 1'b1) begin errors++; $display("FAIL abs_fault_set: got %b expected 1", align_fault); end
    set_cw(1'b0, 2'b01, 1'b0, 1'b0, 2'b00);
    tick();
    tick();
    checks++; if (instr_addr !== 64'h200A) begin errors++; $display("FAIL post_fault_pc: got %h expected %h", instr_addr, 64'h200A); end
    checks++; if (align_fault !== 1'b1) begin errors++; $display("FAIL fault_sticky: got %b expected 1", align_fault); end
    // Asynchronous reset mid-cycle while stalled.
    @(negedge clock);
    stall = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    checks++; if (instr_addr !== 64'h0) begin errors++; $display("FAIL async_reset_pc: got %h expected %h", instr_addr, 64'h0); end
    checks++; if (align_fault !== 1'b0) begin errors++; $display("FAIL async_reset_align: got %b expected 0", align_fault); end
    @(negedge clock);
    stall = 1'b0;
    set_cw(1'b0, 2'b00, 1'b0, 1'b0, 2'b00);
    reset = 1'b1;
    tick();
    checks++; if (instr_addr !== 64'h0) begin errors++; $display("FAIL post_reset_hold: got %h expected %h", instr_addr, 64'h0); end
  endtask

  task automatic test_stall_status();
    stall = 1'b1;
    status_in = 5'h1F;
    set_cw(1'b1, 2'b01, 1'b0, 1'b1, 2'b10);
    tick();
    checks++; if (instr_addr !== 64'h0) begin errors++; $display("FAIL stall_pc: got %h expected %h", instr_addr, 64'h0); end
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL stall_state: got %h expected %h", state, 2'b00); end
    checks++; if (status !== 5'h00) begin errors++; $display("FAIL stall_status: got %h expected %h", status, 5'h00); end
    checks++; if (data_bus_out !== 64'h4) begin errors++; $display("FAIL stall_link: got %h expected %h", data_bus_out, 64'h4); end
    stall = 1'b0;
    tick();
    checks++; if (instr_addr !== 64'h4) begin errors++; $display("FAIL unstall_pc: got %h expected %h", instr_addr, 64'h4); end
    checks++; if (status !== 5'h1F) begin errors++; $display("FAIL unstall_status: got %h expected %h", status, 5'h1F); end
    checks++; if (state !== 2'b10) begin errors++; $display("FAIL unstall_state: got %h expected %h", state, 2'b10); end
    status_in = 5'h0A;
    set_cw(1'b0, 2'b00, 1'b0, 1'b0, 2'b01);
    tick();
    checks++; if (status !== 5'h1F) begin errors++; $display("FAIL status_hold: got %h expected %h", status, 5'h1F); end
    set_cw(1'b0, 2'b00, 1'b0, 1'b1, 2'b01);
    tick();
    checks++; if (status !== 5'h0A) begin errors++; $display("FAIL status_load2: got %h expected %h", status, 5'h0A); end
  endtask

  task automatic test_link_wrap();
    constant = 64'hFFFF_FFFF_FFFF_FFFC;
    set_cw(1'b0, 2'b10, 1'b1, 1'b0, 2'b00);
    tick();
    checks++; if (instr_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL wrap_load_pc: got %h expected %h", instr_addr, 64'hFFFF_FFFF_FFFF_FFFC); end
    checks++; if (align_fault !== 1'b0) begin errors++; $display("FAIL wrap_align: got %b expected 0", align_fault); end
    set_cw(1'b1, 2'b01, 1'b0, 1'b0, 2'b00);
    #1;
    checks++; if (data_bus_out !== 64'h0) begin errors++; $display("FAIL wrap_link: got %h expected %h", data_bus_out, 64'h0); end
    checks++; if (data_bus_pc_enable !== 1'b1) begin errors++; $display("FAIL wrap_dbe: got %b expected 1", data_bus_pc_enable); end
    tick();
    checks++; if (instr_addr !== 64'h0) begin errors++; $display("FAIL wrap_pc: got %h expected %h", instr_addr, 64'h0); end
    checks++; if (data_bus_out !== 64'h4) begin errors++; $display("FAIL post_wrap_link: got %h expected %h", data_bus_out, 64'h4); end
    set_cw(1'b0, 2'b00, 1'b0, 1'b0, 2'b00);
    #1;
    checks++; if (data_bus_out !== 64'h0) begin errors++; $display("FAIL link_off: got %h expected %h", data_bus_out, 64'h0); end
    checks++; if (data_bus_pc_enable !== 1'b0) begin errors++; $display("FAIL dbe_off: got %b expected 0", data_bus_pc_enable); end
  endtask

`ifdef PC_BRANCH_HISTORY_EN
  task automatic test_history();
    logic [63:0] exp_hist [4];
    exp_hist[0] = 64'h50;
    exp_hist[1] = 64'h40;
    exp_hist[2] = 64'h30;
    exp_hist[3] = 64'h20;
    hist_index = 2'd0;
    do_reset();
    #1;
    checks++; if (hist_count !== 3'd0) begin errors++; $display("FAIL hist_reset_count: got %0d expected 0", hist_count); end
    set_cw(1'b0, 2'b01, 1'b0, 1'b0, 2'b00);
    for (int i = 0; i < 4; i++) tick();
    for (int i = 0; i < 5; i++) begin
      constant = 64'h20 + 64'h10 * i;
      set_cw(1'b0, 2'b10, 1'b1, 1'b0, 2'b00);
      tick();
    end
    checks++; if (hist_count !== 3'd4) begin errors++; $display("FAIL hist_count: got %0d expected 4", hist_count); end
    for (int i = 0; i < 4; i++) begin
      hist_index = 2'(i);
      #1;
      checks++; if (hist_pc !== exp_hist[i]) begin errors++; $display("FAIL hist_pc[%0d]: got %h expected %h", i, hist_pc, exp_hist[i]); end
    end
  endtask
`endif

  initial begin
`ifdef PC_BRANCH_HISTORY_EN
    hist_index = 2'd0;
`endif
    test_reset();
    test_relative_branch();
    test_abs_fault();
    test_stall_status();
    test_link_wrap();
`ifdef PC_BRANCH_HISTORY_EN
    test_history();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
